// File: rtl/pdp8_mem_pkg.sv
// Shared types and widths for the PDP-8 32Kx12 memory sequencer.
// Also holds the default strobe timings.
package pdp8_mem_pkg;

    localparam int MA_W   = 12;
    localparam int FLD_W  = 3;
    localparam int RA_W   = 15;
    localparam int WORD_W = 12;
    localparam int CNT_W  = 4;

    localparam int RD_WAIT_DEF  = 2;
    localparam int WR_PULSE_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RDWAIT,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    // Field is the top of the RAM address; nothing carries out of it.
    function automatic logic [RA_W-1:0] mk_addr(
        input logic [FLD_W-1:0] f,
        input logic [MA_W-1:0]  a
    );
        return {f, a};
    endfunction

endpackage

// File: rtl/mem_arb2.sv
// Fixed-priority two-way request select; the high input always wins.
// Used for data-break (DMA) ahead of the CPU when MEM_DMA_EN is defined.
module mem_arb2 (
    input  logic i_req_hi,
    input  logic i_req_lo,
    output logic o_gnt_hi,
    output logic o_gnt_lo,
    output logic o_any
);

    assign o_gnt_hi = i_req_hi;
    assign o_gnt_lo = i_req_lo & ~i_req_hi;
    assign o_any    = i_req_hi | i_req_lo;

endmodule

// File: rtl/mem_seq_32kx12.sv
// Sequencer from the PDP-8 memory port to a 32Kx12 async SRAM.
// Define MEM_DMA_EN to add a data-break requester with priority.
module mem_seq_32kx12
    import pdp8_mem_pkg::*;
#(
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WR_PULSE = WR_PULSE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [FLD_W-1:0]  cpu_field,
    input  logic [MA_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
`ifdef MEM_DMA_EN
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [FLD_W-1:0]  dma_field,
    input  logic [MA_W-1:0]   dma_addr,
    input  logic [WORD_W-1:0] dma_wdata,
    output logic              dma_ack,
`endif
    output logic              busy,
    output logic [RA_W-1:0]   ram_a,
    output logic [WORD_W-1:0] ram_di,
    input  logic [WORD_W-1:0] ram_do,
    output logic              ram_ce_n,
    output logic              ram_we_n
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              r_op_we;
    logic              w_op_we_nx;
    logic [RA_W-1:0]   r_ram_a;
    logic [RA_W-1:0]   w_ram_a_nx;
    logic [WORD_W-1:0] r_ram_di;
    logic [WORD_W-1:0] w_ram_di_nx;
    logic              r_ce_n;
    logic              w_ce_n_nx;
    logic              r_we_n;
    logic              w_we_n_nx;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] w_rdata_nx;
    logic              r_ack;
    logic              w_ack_nx;

    logic              w_req;
    logic              w_sel_we;
    logic [FLD_W-1:0]  w_sel_field;
    logic [MA_W-1:0]   w_sel_addr;
    logic [WORD_W-1:0] w_sel_wdata;

`ifdef MEM_DMA_EN
    logic r_src_dma;
    logic w_src_dma_nx;
    logic w_gnt_dma;
    logic w_gnt_cpu;

    mem_arb2 u_arb (
        .i_req_hi (dma_req),
        .i_req_lo (cpu_req),
        .o_gnt_hi (w_gnt_dma),
        .o_gnt_lo (w_gnt_cpu),
        .o_any    (w_req)
    );

    assign w_sel_we    = w_gnt_dma ? dma_we    : cpu_we;
    assign w_sel_field = w_gnt_dma ? dma_field : cpu_field;
    assign w_sel_addr  = w_gnt_dma ? dma_addr  : cpu_addr;
    assign w_sel_wdata = w_gnt_dma ? dma_wdata : cpu_wdata;
    assign w_src_dma_nx = (r_state == S_IDLE && w_req) ? w_gnt_dma : r_src_dma;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_src_dma <= 1'b0;
        else          r_src_dma <= w_src_dma_nx;
    end

    assign cpu_ack = r_ack & ~r_src_dma;
    assign dma_ack = r_ack & r_src_dma;
    wire   w_unused_gnt = w_gnt_cpu;
`else
    assign w_req       = cpu_req;
    assign w_sel_we    = cpu_we;
    assign w_sel_field = cpu_field;
    assign w_sel_addr  = cpu_addr;
    assign w_sel_wdata = cpu_wdata;
    assign cpu_ack     = r_ack;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_we  <= 1'b0;
            r_ram_a  <= '0;
            r_ram_di <= '0;
            r_ce_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_op_we  <= w_op_we_nx;
            r_ram_a  <= w_ram_a_nx;
            r_ram_di <= w_ram_di_nx;
            r_ce_n   <= w_ce_n_nx;
            r_we_n   <= w_we_n_nx;
            r_rdata  <= w_rdata_nx;
            r_ack    <= w_ack_nx;
        end
    end

    // Strobes are computed one cycle ahead so the RAM pins come straight off flops.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_op_we_nx  = r_op_we;
        w_ram_a_nx  = r_ram_a;
        w_ram_di_nx = r_ram_di;
        w_ce_n_nx   = r_ce_n;
        w_we_n_nx   = r_we_n;
        w_rdata_nx  = r_rdata;
        w_ack_nx    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_ram_a_nx  = mk_addr(w_sel_field, w_sel_addr);
                    w_ram_di_nx = w_sel_wdata;
                    w_op_we_nx  = w_sel_we;
                    w_ce_n_nx   = 1'b0;
                    w_state_nx  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_op_we) begin
                    w_cnt_nx   = WR_LOAD;
                    w_we_n_nx  = 1'b0;
                    w_state_nx = S_STROBE;
                end else begin
                    w_cnt_nx   = RD_LOAD;
                    w_state_nx = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nx = ram_do;
                    w_ce_n_nx  = 1'b1;
                    w_ack_nx   = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_we_n_nx  = 1'b1;
                    w_state_nx = S_HOLD;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                w_ce_n_nx  = 1'b1;
                w_ack_nx   = 1'b1;
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_ce_n_nx  = 1'b1;
                w_we_n_nx  = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign ram_a     = r_ram_a;
    assign ram_di    = r_ram_di;
    assign ram_ce_n  = r_ce_n;
    assign ram_we_n  = r_we_n;
    assign cpu_rdata = r_rdata;

endmodule
